// File: rtl/buzzer_pkg.sv
// Shared types and constants for the buzzer tone sequencer.
package buzzer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam int unsigned CLK_HZ         = 50_000_000;
    localparam int unsigned STEP_W         = 16;
    localparam int unsigned DUR_W          = 16;
    localparam int unsigned ROM_DEPTH      = 8;
    localparam int unsigned ROM_AW         = 3;
    localparam int unsigned DUR_MS_DEFAULT = 200;
    localparam int unsigned DUR_MS_MAX     = DUR_MS_DEFAULT;

    // Phase steps for a 32-bit accumulator at 50 MHz: C4 D4 E4 F4 G4 A4 B4 C5.
    // Element 0 is the rightmost entry.
    localparam logic [ROM_DEPTH-1:0][STEP_W-1:0] STEP_TABLE = {
        16'd44925, 16'd42434, 16'd37796, 16'd33673,
        16'd29979, 16'd28347, 16'd25254, 16'd22506
    };

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/buzzer_tone_rom.sv
// Combinational note table: phase step and duration for a note index.
module buzzer_tone_rom
    import buzzer_pkg::*;
#(
    parameter int unsigned IW = 3
) (
    input  logic [IW-1:0]     idx_i,
    output logic [STEP_W-1:0] step_o,
    output logic [DUR_W-1:0]  dur_ms_o
);

    logic [31:0] idx_ext;

    // Look up the note; indices past the table read as a silent, zero-length note.
    always_comb begin
        idx_ext  = 32'(idx_i);
        step_o   = '0;
        dur_ms_o = '0;
        if (idx_ext < ROM_DEPTH) begin
            step_o   = STEP_TABLE[idx_ext[ROM_AW-1:0]];
            dur_ms_o = DUR_W'(DUR_MS_DEFAULT);
        end
    end

endmodule

// File: rtl/buzzer_tone_seq.sv
// Plays the note table once per start pulse: each note for its duration,
// followed by a silent gap, then pulses done. All outputs are registered.
module buzzer_tone_seq
    import buzzer_pkg::*;
#(
    parameter int N           = 32,
    parameter int TICK_CYCLES = CLK_HZ / 1000,
    parameter int NOTE_NUM    = 8,
    parameter int GAP_MS      = 20
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        stop,
    output logic [N-1:0]                period,
    output logic [N-1:0]                duty,
    output logic                        tone_en,
    output logic                        busy,
    output logic [$clog2(NOTE_NUM)-1:0] note_idx,
    output logic                        done
);

    localparam int IW     = $clog2(NOTE_NUM);
    localparam int TW     = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int MS_MAX = int'(max_u(DUR_MS_MAX, GAP_MS));
    localparam int MW     = $clog2(MS_MAX + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [MW-1:0] GAP_LAST  = MW'(GAP_MS - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NOTE_NUM - 1);
    localparam logic [N-1:0]  DUTY_HALF = {1'b1, {(N-1){1'b0}}};

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [MW-1:0]   ms_q, ms_d;
    logic            seq_end;

    logic [N-1:0]    period_q, period_d;
    logic [N-1:0]    duty_q, duty_d;
    logic            tone_en_q, tone_en_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [IW-1:0]     rom_idx;
    logic [STEP_W-1:0] rom_step;
    logic [DUR_W-1:0]  rom_dur_ms;
    logic              tick_wrap;
    logic              play_last;
    logic              gap_last;

    // The ROM is addressed with the note that will be playing after the next
    // edge when the sequence advances, so the registered period is valid on
    // the first cycle of every note; in PLAY this is also the current note.
    always_comb begin
        rom_idx = '0;
        if (state_q == ST_PLAY) begin
            rom_idx = idx_q;
        end else if (state_q == ST_GAP) begin
            rom_idx = idx_q + IW'(1);
        end
    end

    buzzer_tone_rom #(
        .IW (IW)
    ) u_rom (
        .idx_i    (rom_idx),
        .step_o   (rom_step),
        .dur_ms_o (rom_dur_ms)
    );

    assign tick_wrap = (tick_q == TICK_LAST);
    assign play_last = (state_q == ST_PLAY) && tick_wrap && (ms_q == MW'(rom_dur_ms - 1'b1));
    assign gap_last  = (state_q == ST_GAP) && tick_wrap && (ms_q == GAP_LAST);

    // State register plus the registered outputs; reset is synchronous only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            tick_q    <= '0;
            ms_q      <= '0;
            period_q  <= '0;
            duty_q    <= '0;
            tone_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tick_q    <= tick_d;
            ms_q      <= ms_d;
            period_q  <= period_d;
            duty_q    <= duty_d;
            tone_en_q <= tone_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next state, note index and timing counters; stop overrides everything.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        seq_end = 1'b0;
        if (stop) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_PLAY;
                        idx_d   = '0;
                    end
                end
                ST_PLAY: begin
                    if (play_last) begin
                        state_d = ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_last) begin
                        if (idx_q != IDX_LAST) begin
                            state_d = ST_PLAY;
                            idx_d   = idx_q + IW'(1);
                        end else begin
                            state_d = ST_IDLE;
                            idx_d   = '0;
                            seq_end = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            endcase
        end

        // Every state change (including GAP->PLAY) restarts timing from zero.
        tick_d = tick_q;
        ms_d   = ms_q;
        if ((state_d != state_q) || (state_q == ST_IDLE)) begin
            tick_d = '0;
            ms_d   = '0;
        end else if (tick_wrap) begin
            tick_d = '0;
            ms_d   = ms_q + MW'(1);
        end else begin
            tick_d = tick_q + TW'(1);
        end
    end

    // Output values for the state being entered, registered on the same edge.
    always_comb begin
        period_d  = '0;
        duty_d    = '0;
        tone_en_d = 1'b0;
        busy_d    = (state_d != ST_IDLE);
        done_d    = seq_end;
        if (state_d == ST_PLAY) begin
            period_d  = N'(rom_step);
            duty_d    = DUTY_HALF;
            tone_en_d = 1'b1;
        end
    end

    assign period   = period_q;
    assign duty     = duty_q;
    assign tone_en  = tone_en_q;
    assign busy     = busy_q;
    assign note_idx = idx_q;
    assign done     = done_q;

endmodule

// File: tb/tb_buzzer_tone_seq.sv
// Scoreboard bench for buzzer_tone_seq with TICK_CYCLES=10, GAP_MS=2.
module tb_buzzer_tone_seq;

    localparam int PLAY_CYC = 2000;
    localparam int NOTE_CYC = 2020;
    localparam int NOTES    = 8;
    localparam int RUN_CYC  = NOTES * NOTE_CYC;
    localparam int STEPS [8] = '{22506, 25254, 28347, 29979, 33673, 37796, 42434, 44925};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] period;
    logic [31:0] duty;
    logic        tone_en;
    logic        busy;
    logic [2:0]  note_idx;
    logic        done;

    int checks = 0;
    int failures = 0;
    logic [69:0] exp_q[$];

    buzzer_tone_seq #(
        .N           (32),
        .TICK_CYCLES (10),
        .NOTE_NUM    (8),
        .GAP_MS      (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .period   (period),
        .duty     (duty),
        .tone_en  (tone_en),
        .busy     (busy),
        .note_idx (note_idx),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Expected {period, duty, tone_en, busy, note_idx, done} k cycles after
    // the edge that sampled start, for an undisturbed run.
    function automatic logic [69:0] model(input int k);
        logic [31:0] p;
        logic [31:0] d;
        logic        t;
        logic        b;
        logic [2:0]  ix;
        logic        dn;
        int          note;
        int          r;
        p = '0; d = '0; t = 1'b0; b = 1'b0; ix = '0; dn = 1'b0;
        if (k < RUN_CYC) begin
            note = k / NOTE_CYC;
            r    = k % NOTE_CYC;
            b    = 1'b1;
            ix   = 3'(note);
            if (r < PLAY_CYC) begin
                p = 32'(STEPS[note]);
                d = 32'h8000_0000;
                t = 1'b1;
            end
        end else if (k == RUN_CYC) begin
            dn = 1'b1;
        end
        return {p, d, t, b, ix, dn};
    endfunction

    task automatic test_reset();
        logic [69:0] e;
        logic [69:0] obs;
        for (int i = 0; i < 5; i++) begin
            rst_n = (i >= 3);
            start = (i == 1);
            stop  = 1'b0;
            exp_q.push_back('0);
            @(posedge clk); #1;
            e   = exp_q.pop_front();
            obs = {period, duty, tone_en, busy, note_idx, done};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL reset i=%0d got=%h exp=%h", i, obs, e);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_full_run();
        logic [69:0] e;
        logic [69:0] obs;
        for (int i = 0; i <= RUN_CYC + 3; i++) begin
            start = (i == 0);
            stop  = 1'b0;
            exp_q.push_back(model(i));
            @(posedge clk); #1;
            e   = exp_q.pop_front();
            obs = {period, duty, tone_en, busy, note_idx, done};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL full_run k=%0d got=%h exp=%h", i, obs, e);
            end
        end
        start = 1'b0;
    endtask

    // Retriggers during note 3 and in later notes must be ignored; the run
    // is then stopped on the very edge the final gap expires, so no done.
    task automatic test_start_while_busy();
        logic [69:0] e;
        logic [69:0] obs;
        for (int i = 0; i <= RUN_CYC + 3; i++) begin
            start = (i == 0) || (i == 3 * NOTE_CYC + 500) ||
                    (i == 3 * NOTE_CYC + PLAY_CYC + 5) || (i == RUN_CYC - 1);
            stop  = (i == RUN_CYC);
            exp_q.push_back((i < RUN_CYC) ? model(i) : 70'd0);
            @(posedge clk); #1;
            e   = exp_q.pop_front();
            obs = {period, duty, tone_en, busy, note_idx, done};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL start_while_busy k=%0d got=%h exp=%h", i, obs, e);
            end
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic test_stop_in_play();
        logic [69:0] e;
        logic [69:0] obs;
        int s;
        s = 5 * NOTE_CYC + 100;
        for (int i = 0; i <= s + 60; i++) begin
            start = (i == 0) || (i == s + 10);
            stop  = (i == s) || (i == s + 50);
            if (i < s)            exp_q.push_back(model(i));
            else if (i < s + 10)  exp_q.push_back('0);
            else if (i < s + 50)  exp_q.push_back(model(i - s - 10));
            else                  exp_q.push_back('0);
            @(posedge clk); #1;
            e   = exp_q.pop_front();
            obs = {period, duty, tone_en, busy, note_idx, done};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL stop_in_play i=%0d got=%h exp=%h", i, obs, e);
            end
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic test_start_stop_same();
        logic [69:0] e;
        logic [69:0] obs;
        for (int i = 0; i < 10; i++) begin
            start = (i == 0) || (i == 4);
            stop  = (i == 0) || (i == 4);
            exp_q.push_back('0);
            @(posedge clk); #1;
            e   = exp_q.pop_front();
            obs = {period, duty, tone_en, busy, note_idx, done};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL start_stop_same i=%0d got=%h exp=%h", i, obs, e);
            end
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic test_reset_in_last_gap();
        logic [69:0] e;
        logic [69:0] obs;
        for (int i = 0; i <= RUN_CYC + 3; i++) begin
            start = (i == 0);
            stop  = 1'b0;
            rst_n = (i != RUN_CYC);
            exp_q.push_back((i < RUN_CYC) ? model(i) : 70'd0);
            @(posedge clk); #1;
            e   = exp_q.pop_front();
            obs = {period, duty, tone_en, busy, note_idx, done};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL reset_in_last_gap k=%0d got=%h exp=%h", i, obs, e);
            end
        end
        start = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_start_while_busy();
        test_stop_in_play();
        test_start_stop_same();
        test_reset_in_last_gap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/buzzer_tone_seq.md
BUZZER_TONE_SEQ -- requirements
Module: buzzer_tone_seq

Interface
REQ-001 SHALL have parameter N, default 32, meaning the width of the phase step and duty words driven to the downstream pwm.
REQ-002 SHALL have parameter TICK_CYCLES, default 50_000, meaning clk cycles per 1 ms tick at 50 MHz.
REQ-003 SHALL have parameter NOTE_NUM, default 8, meaning the number of notes in the sequence.
REQ-004 SHALL have parameter GAP_MS, default 20, meaning the silent gap in ms after each note.
REQ-005 SHALL have port clk, input, 1 bit: the single system clock.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port start, input, 1 bit: a one-cycle pulse that starts the sequence (e.g. a debounced key negedge).
REQ-008 SHALL have port stop, input, 1 bit: a one-cycle pulse that aborts the sequence.
REQ-009 SHALL have port period, output, N bits: the phase step for pwm, 0 when silent.
REQ-010 SHALL have port duty, output, N bits: the duty threshold for pwm.
REQ-011 SHALL have port tone_en, output, 1 bit: high while a note is sounding.
REQ-012 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-013 SHALL have port note_idx, output, $clog2(NOTE_NUM) bits: the current note index.
REQ-014 SHALL have port done, output, 1 bit: a one-cycle pulse on normal sequence completion.

Function
REQ-015 SHALL implement FSM states IDLE, PLAY and GAP; all outputs SHALL be registered.
REQ-016 IDLE: on start=1 and stop=0, the next state SHALL be PLAY with note_idx=0; period, duty and tone_en SHALL be valid on the cycle after start (1-cycle latency).
REQ-017 PLAY: period SHALL equal ROM step[note_idx], duty SHALL equal 2^(N-1) (50%), and tone_en SHALL be 1 for exactly dur[note_idx]*TICK_CYCLES cycles, after which the state SHALL be GAP.
REQ-018 GAP: period, duty and tone_en SHALL be 0 for exactly GAP_MS*TICK_CYCLES cycles.
- If note_idx < NOTE_NUM-1, the block SHALL then increment note_idx and enter PLAY.
- Otherwise it SHALL enter IDLE, set note_idx=0, and pulse done.
REQ-019 Timing SHALL use a tick counter (0..TICK_CYCLES-1) plus a ms counter; both SHALL clear on every state entry so that no residual count carries over between notes.
REQ-020 start while busy=1 SHALL be ignored (no restart, no retrigger).
REQ-021 stop in any state SHALL force IDLE on the next cycle with period=0, duty=0, tone_en=0 and note_idx=0, and SHALL NOT pulse done; stop SHALL win over a simultaneous start.
REQ-022 stop coinciding with the final GAP expiry SHALL still suppress done.
REQ-023 Counter widths SHALL hold TICK_CYCLES-1 and the largest ms duration without overflow; step values SHALL be zero-extended to N bits.
REQ-024 ROM step[i] SHALL equal round(f_i*2^32/50e6) for f = 262, 294, 330, 349, 392, 440, 494, 523 Hz, i.e. 22506, 25254, 28347, 29979, 33673, 37796, 42434, 44925; dur[i] SHALL be 200 ms for all i.

Reset
REQ-025 With rst_n=0 at a clk edge, the block SHALL enter state IDLE and clear all counters.
REQ-026 With rst_n=0 at a clk edge, outputs SHALL be period=0, duty=0, tone_en=0, busy=0, note_idx=0 and done=0.
REQ-027 Reset asserted mid-sequence SHALL behave as stop, with no done pulse.
REQ-028 Reset SHALL have no asynchronous path.

Structure
REQ-029 The state encoding, default step table and 50 MHz clock constant SHALL live in a shared package, buzzer_pkg.
REQ-030 The note table SHALL be a combinational sub-module, buzzer_tone_rom (index in; step and dur_ms out).
REQ-031 Target RTL size SHALL be 120-400 lines.

Verification (TICK_CYCLES=10, GAP_MS=2 in sim)
REQ-032 Start pulse -> busy=1 the next cycle, period=22506, duty=0x8000_0000, tone_en=1 held for 2000 cycles, then period=0 for 20 cycles, then period=25254.
REQ-033 Full run -> 8 notes in order, done high for exactly 1 cycle at cycle 1+8*2020, busy=0 afterwards.
REQ-034 Start during note 3 -> no change to note_idx or timing versus an undisturbed run.
REQ-035 Stop during note 5 PLAY -> next cycle IDLE, all outputs 0, no done pulse; a subsequent start restarts at note 0.
REQ-036 Start and stop in the same cycle from IDLE -> the block remains IDLE.
REQ-037 rst_n=0 in GAP after note 7 -> no done pulse, all outputs at reset values on the following cycle.
